// File: rtl/enc4x2_pkg.sv
// enc4x2_pkg: shared state type, widths and one-hot helper for the 4-to-2 sequential encoder
package enc4x2_pkg;
  localparam int LINES = 4;
  localparam int CODE_W = 2;
  typedef enum logic {IDLE, SERVE} state_t;
  function automatic logic is_one(input logic [LINES-1:0] v);
    return v != '0 && (v & (v - LINES'(1))) == '0;
  endfunction
endpackage

// File: rtl/enc4x2_prio.sv
// enc4x2_prio: combinational priority pick of pend -> code and the one-hot mask of the picked line (mask=0 when pend=0)
module enc4x2_prio
  import enc4x2_pkg::*;
#(
  parameter bit PRIO_HIGH_FIRST = 1'b1
) (
  input  logic [LINES-1:0]  pend,
  output logic [CODE_W-1:0] code,
  output logic [LINES-1:0]  mask
);
  always_comb begin
    code = PRIO_HIGH_FIRST ? (pend[3] ? 2'd3 : pend[2] ? 2'd2 : pend[1] ? 2'd1 : 2'd0)
                           : (pend[0] ? 2'd0 : pend[1] ? 2'd1 : pend[2] ? 2'd2 : pend[3] ? 2'd3 : 2'd0);
    mask = pend & (LINES'(1) << code);
  end
endmodule

// File: rtl/encoder_4x2_seq.sv
// encoder_4x2_seq: captures y_in via valid/ready, emits one {a_out,b_out} code per set line in priority order; ENC4X2_ZERO_FLAG_EN turns an all-zero vector into a single zero_out beat
module encoder_4x2_seq
  import enc4x2_pkg::*;
#(
  parameter bit PRIO_HIGH_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [LINES-1:0] y_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             a_out,
  output logic             b_out,
  output logic             last_out,
  output logic             zero_out
);
`ifdef ENC4X2_ZERO_FLAG_EN
  localparam bit ZF = 1'b1;
`else
  localparam bit ZF = 1'b0;
`endif
  state_t st;
  logic [LINES-1:0] pend, mask;
  logic [CODE_W-1:0] code;
  logic zflag, take, give;
  enc4x2_prio #(.PRIO_HIGH_FIRST(PRIO_HIGH_FIRST)) u_prio (.pend(pend), .code(code), .mask(mask));
  always_comb begin
    out_valid = st == SERVE;
    {a_out, b_out} = out_valid ? code : '0;
    last_out = out_valid & (zflag | is_one(pend));
    zero_out = zflag;
    give = out_valid & out_ready;
    in_ready = ~rst & (~out_valid | (out_ready & last_out));
    take = in_valid & in_ready;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      st <= IDLE;
      pend <= '0;
      zflag <= 1'b0;
    end else if (take) begin
      st <= (y_in != '0 || ZF) ? SERVE : IDLE;
      pend <= y_in;
      zflag <= ZF && y_in == '0;
    end else if (give) begin
      pend <= pend & ~mask;
      zflag <= 1'b0;
      if (last_out) st <= IDLE;
    end
  end
endmodule
